jk_cmd_sequencer: RTL and testbench
===================================

// Module: jk_cmd_sequencer
// PURPOSE
//  Command-driven controller for a bank of WIDTH JK flip-flops. Accepts HOLD/RESET/SET/TOGGLE
//  commands over a valid/ready handshake and drives J/K of the masked cells for a
//  programmed number of clock edges. Pulses done on completion.
//  Sits between a register-write/test master and the JK storage bank it owns.
// PARAMETERS
//  WIDTH  8  number of JK cells in the bank (1..32)
//  CNT_W  4  width of cmd_len; max apply length 2**CNT_W-1 edges
// PORTS
//  clk        in   1      rising-edge clock
//  n_rst      in   1      asynchronous reset, active-low; all state and outputs clear immediately
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept; =1 only in IDLE
//  cmd_op     in   2      00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//  cmd_mask   in   WIDTH  1 = cell affected by command
//  cmd_len    in   CNT_W  number of edges to apply op; 0 treated as 1
//  busy       out  1      1 in APPLY or DONE
//  done       out  1      1-cycle pulse when command finishes
//  q          out  WIDTH  JK bank outputs
//  abort      in   1      [JKSEQ_ABORT_EN only] stop current command
//  aborted    out  1      [JKSEQ_ABORT_EN only] qualifies done; 1 when command was cut short
// BEHAVIOUR
//  Reset (n_rst=0): state=IDLE, q=0, done=0, busy=0, cmd_ready=1, internal op/mask/cnt=0.
//  States: IDLE -> APPLY -> DONE -> IDLE.
//  IDLE: cmd_ready=1, J=K=0. On cmd_valid&cmd_ready at edge E0: latch op, mask,
//   cnt = max(cmd_len,1)-1; go APPLY. cmd_* inputs ignored outside the handshake.
//  APPLY: J = mask & {WIDTH{op[1]}}, K = mask & {WIDTH{op[0]}}, driven combinationally from
//   latched regs; bank updates on every APPLY edge (JK rules: 00 hold, 01 clear, 10 set, 11 toggle).
//   Each edge: if cnt==0 go DONE else cnt--. Unmasked cells always hold.
//  DONE: J=K=0, done=1 for exactly one cycle, go IDLE.
//  Latency: accept at E0, q updates at E1..E_L (L=max(cmd_len,1)), done high in cycle after E_L,
//   cmd_ready high after E_(L+1). Throughput: one command per L+2 cycles.
//  q final value is visible in the same cycle done=1.
//  HOLD op still consumes L apply cycles and pulses done (used as a timed delay).
//  cmd_mask=0 behaves as HOLD. cnt never underflows; no wrap-around.
//  n_rst asserted mid-command: command discarded, q=0, no done pulse.
// CONFIGURATION
//  JKSEQ_ABORT_EN defined: abort port present. abort=1 sampled in APPLY forces J=K=0 that
//   cycle (no bank update at that edge), next state DONE, done=1 with aborted=1.
//   abort in IDLE/DONE ignored; aborted=0 whenever done=0. Simultaneous abort and final
//   count edge: abort wins (last update suppressed, aborted=1).
//  JKSEQ_ABORT_EN undefined: abort/aborted ports absent; every command runs to completion.
// STRUCTURE
//  Package jk_seq_pkg: op enum (OP_HOLD/OP_RESET/OP_SET/OP_TOGGLE), state enum
//   (ST_IDLE/ST_APPLY/ST_DONE).
//  Sub-module jk_bank: WIDTH JK cells, ports clk, n_rst, j[WIDTH], k[WIDTH], q[WIDTH];
//   async active-low clear. Sequencer holds FSM, latches, counter only.
// TESTING
//  1 Reset: n_rst=0 with random inputs -> q=0x00, done=0, busy=0, cmd_ready=1.
//  2 SET mask=0xF0 len=1 from q=0 -> q=0xF0 one cycle after accept, done pulse next cycle, ready after.
//  3 TOGGLE mask=0x03 len=3 from q=0xF0 -> q=0xF3; q bit0 alternates each edge; done once.
//  4 RESET mask=0x80 len=0 -> treated as 1 edge, q=0x73; HOLD mask=0xFF len=5 -> q unchanged, done after 5 edges.
//  5 Handshake: cmd_valid held high through busy -> second command accepted only when cmd_ready=1; no drop, no duplicate.
//  6 Mid-command reset during TOGGLE len=10 -> q=0 immediately, no done; with JKSEQ_ABORT_EN,
//    abort at 3rd APPLY cycle -> exactly 2 toggles applied, done=1 with aborted=1.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types for the JK command sequencer: command opcodes, FSM states and the JK cell rule.
package jk_seq_pkg;

  localparam int unsigned JK_WIDTH_DEF = 8;
  localparam int unsigned JK_CNT_W_DEF = 4;
  localparam int unsigned JK_OP_W      = 2;

  typedef enum logic [JK_OP_W-1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Bitwise JK next-state: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic [31:0] jk_next(input logic [31:0] j, input logic [31:0] k,
                                          input logic [31:0] q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with asynchronous active-low clear.
module jk_bank
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = JK_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = WIDTH'(jk_next(32'(j), 32'(k), 32'(q_q)));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command-driven controller for a JK bank: HOLD/RESET/SET/TOGGLE on masked cells for N edges.
// Optional abort support is compiled in with JKSEQ_ABORT_EN.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = JK_WIDTH_DEF,
  parameter int unsigned CNT_W = JK_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
`ifdef JKSEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] q
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] j_c, k_c;
  logic             abort_c;

`ifdef JKSEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Next state, command latches and bank drive.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    j_c     = '0;
    k_c     = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          mask_d  = cmd_mask;
          cnt_d   = (cmd_len == '0) ? '0 : cmd_len - CNT_W'(1);
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (abort_c) begin
          // Abort suppresses this edge's update and finishes early.
          state_d = ST_DONE;
        end else begin
          case (op_q)
            OP_RESET:  k_c = mask_q;
            OP_SET:    j_c = mask_q;
            OP_TOGGLE: begin
              j_c = mask_q;
              k_c = mask_q;
            end
            default: ;
          endcase
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      mask_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef JKSEQ_ABORT_EN
  logic aborted_q, aborted_d;

  // Only an abort seen in APPLY leads into DONE, so aborted is never high without done.
  always_comb begin
    aborted_d = (state_q == ST_APPLY) && abort_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign done      = done_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .n_rst(n_rst),
    .j    (j_c),
    .k    (k_c),
    .q    (q)
  );

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: timeline-based reference model plus directed literals.
module tb_jk_cmd_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             n_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
`ifdef JKSEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  jk_cmd_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_len  (cmd_len),
    .busy     (busy),
    .done     (done),
`ifdef JKSEQ_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // Reference model: a command is a timeline of edges t=1.. after its accept edge.
  bit         m_active;
  bit         m_acc;
  bit         m_ab;
  int         m_t;
  int         m_end;
  int         m_applied;
  logic [1:0] m_op;
  logic [7:0] m_mask;
  logic [7:0] m_base;

  function automatic logic [7:0] apply_n(input logic [7:0] b, input logic [1:0] op,
                                         input logic [7:0] m, input int n);
    if (n == 0) return b;
    case (op)
      2'b00:   return b;
      2'b01:   return b & ~m;
      2'b10:   return b | m;
      default: return (n % 2 == 1) ? (b ^ m) : b;
    endcase
  endfunction

  function automatic logic [7:0] exp_q();
    if (!m_active) return m_base;
    return apply_n(m_base, m_op, m_mask, (m_t < m_applied) ? m_t : m_applied);
  endfunction

  task automatic m_clear();
    m_active = 0;
    m_acc    = 0;
    m_ab     = 0;
    m_base   = '0;
  endtask

  task automatic model_step();
    m_acc = 0;
    if (!m_active) begin
      if (cmd_valid) begin
        m_active  = 1;
        m_acc     = 1;
        m_ab      = 0;
        m_t       = 0;
        m_op      = cmd_op;
        m_mask    = cmd_mask;
        m_end     = (cmd_len == 0) ? 1 : int'(cmd_len);
        m_applied = m_end;
      end
    end else begin
      m_t++;
`ifdef JKSEQ_ABORT_EN
      if (abort && m_t <= m_end && !m_ab) begin
        m_ab      = 1;
        m_end     = m_t;
        m_applied = m_t - 1;
      end
`endif
      if (m_t > m_end) begin
        m_base   = apply_n(m_base, m_op, m_mask, m_applied);
        m_active = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_done;
    exp_done = m_active && (m_t == m_end);
    chk("q", 32'(q), 32'(exp_q()));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(exp_done));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_active));
`ifdef JKSEQ_ABORT_EN
    chk("aborted", 32'(aborted), 32'(exp_done && m_ab));
`endif
    if (done) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] len);
    bit acc;
    acc       = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_len   = len;
    for (int i = 0; i < 60 && !acc; i++) begin
      tick();
      if (m_acc) acc = 1;
    end
    cmd_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && m_active; i++) tick();
    chk("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic rand_inputs();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_mask  = 8'($urandom);
    cmd_len   = 4'($urandom_range(0, 6));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int acc_cnt;
    int busy_cyc;
    n_rst     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_mask  = '0;
    cmd_len   = '0;
`ifdef JKSEQ_ABORT_EN
    abort     = 1'b0;
`endif
    m_clear();

    // Reset with random inputs applied.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_inputs();
      #1;
      check_all();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_rst     = 1'b1;
    tick();

    // SET 0xF0 len 1.
    send(2'b10, 8'hF0, 4'd1);
    chk("set_q_at_accept", 32'(q), 32'h00);
    tick();
    chk("set_q", 32'(q), 32'hF0);
    chk("set_done", 32'(done), 32'd1);
    tick();
    chk("set_ready_after", 32'(cmd_ready), 32'd1);

    // TOGGLE 0x03 len 3: bit0 alternates each edge.
    d0 = done_seen;
    send(2'b11, 8'h03, 4'd3);
    tick(); chk("tgl_e1", 32'(q), 32'hF3);
    tick(); chk("tgl_e2", 32'(q), 32'hF0);
    tick(); chk("tgl_e3", 32'(q), 32'hF3);
    chk("tgl_done", 32'(done), 32'd1);
    wait_idle();
    chk("tgl_done_once", 32'(done_seen - d0), 32'd1);

    // RESET 0x80 len 0 acts as one edge.
    send(2'b01, 8'h80, 4'd0);
    tick();
    chk("rst_op_q", 32'(q), 32'h73);
    chk("rst_op_done", 32'(done), 32'd1);
    wait_idle();

    // HOLD len 5 works as a timed delay.
    send(2'b00, 8'hFF, 4'd5);
    busy_cyc = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      busy_cyc++;
    end
    chk("hold_cycles_to_done", 32'(busy_cyc), 32'd6);
    chk("hold_q", 32'(q), 32'h73);
    wait_idle();

    // cmd_valid held high: each accepted command completes exactly once.
    d0      = done_seen;
    acc_cnt = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cmd_op   = 2'($urandom);
      cmd_mask = 8'($urandom);
      cmd_len  = 4'($urandom_range(0, 4));
      tick();
      if (m_acc) acc_cnt++;
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("hs_acc_eq_done", 32'(acc_cnt), 32'(done_seen - d0));

    // Reset mid-command.
    send(2'b11, 8'hFF, 4'd10);
    tick(); tick(); tick();
    d0    = done_seen;
    n_rst = 1'b0;
    m_clear();
    #1;
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    tick(); tick();
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_no_done", 32'(done_seen - d0), 32'd0);

`ifdef JKSEQ_ABORT_EN
    // Abort sampled on the 3rd APPLY edge: two toggles land.
    send(2'b11, 8'h0F, 4'd10);
    tick(); chk("ab_e1", 32'(q), 32'h0F);
    tick(); chk("ab_e2", 32'(q), 32'h00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_flag", 32'(aborted), 32'd1);
    chk("ab_q", 32'(q), 32'h00);
    tick();
    chk("ab_ready", 32'(cmd_ready), 32'd1);
    // Abort on the final counted edge suppresses that update.
    send(2'b11, 8'h01, 4'd2);
    tick(); chk("abl_e1", 32'(q), 32'h01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abl_q", 32'(q), 32'h01);
    chk("abl_flag", 32'(aborted), 32'd1);
    wait_idle();
`endif

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 500; i++) begin
      if (!n_rst) n_rst = 1'b1;
      rand_inputs();
`ifdef JKSEQ_ABORT_EN
      abort = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        n_rst = 1'b0;
        m_clear();
        #1;
        check_all();
      end
      tick();
    end
    n_rst     = 1'b1;
    cmd_valid = 1'b0;
`ifdef JKSEQ_ABORT_EN
    abort     = 1'b0;
`endif
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
